// File: rtl/xadc_drp_sched.sv
// xadc_drp_sched: arbitrates the single XADC DRP port between a round-robin
// scan of four auxiliary channels (kicked by end-of-conversion) and a host
// read/write port. Keeps the latest upper byte of each scanned channel.
module xadc_drp_sched #(
  parameter logic [6:0]  CH0_ADDR = 7'h1E,
  parameter logic [6:0]  CH1_ADDR = 7'h17,
  parameter logic [6:0]  CH2_ADDR = 7'h1F,
  parameter logic [6:0]  CH3_ADDR = 7'h16,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eoc_in,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [15:0] host_rdata,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [7:0]  data3,
  output logic        sample_stb,
  output logic [1:0]  sample_idx,
  output logic        eoc_ovr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT starts one cycle after den, so DONE lands exactly TIMEOUT cycles after den
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            scan_pend_q, scan_pend_d;
  logic            eoc_ovr_q, eoc_ovr_d;
  logic            last_host_q, last_host_d;
  logic [1:0]      slot_q, slot_d;
  logic            is_host_q, is_host_d;
  logic            dwe_q, dwe_d;
  logic [6:0]      daddr_q, daddr_d;
  logic [15:0]     di_q, di_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            host_ack_q, host_ack_d;
  logic            host_err_q, host_err_d;
  logic [15:0]     host_rdata_q, host_rdata_d;
  logic [3:0][7:0] data_q, data_d;
  logic            sample_stb_q, sample_stb_d;
  logic [1:0]      sample_idx_q, sample_idx_d;

  logic [6:0]      slot_addr;
  logic            grant_host;
  logic            grant_scan;
  logic            done_ok;
  logic            done_err;

  // DRP address of the current scan slot
  always_comb begin
    case (slot_q)
      2'd0:    slot_addr = CH0_ADDR;
      2'd1:    slot_addr = CH1_ADDR;
      2'd2:    slot_addr = CH2_ADDR;
      default: slot_addr = CH3_ADDR;
    endcase
  end

  // Arbitration, access sequencing and completion bookkeeping
  always_comb begin
    state_d      = state_q;
    scan_pend_d  = scan_pend_q;
    eoc_ovr_d    = eoc_ovr_q | (eoc_in & scan_pend_q);
    last_host_d  = last_host_q;
    slot_d       = slot_q;
    is_host_d    = is_host_q;
    dwe_d        = dwe_q;
    daddr_d      = daddr_q;
    di_d         = di_q;
    cnt_d        = cnt_q;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    data_d       = data_q;
    sample_stb_d = 1'b0;
    sample_idx_d = sample_idx_q;
    grant_host   = 1'b0;
    grant_scan   = 1'b0;
    done_ok      = 1'b0;
    done_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_pend_q || host_req) begin
          // On contention the requester not served last wins
          grant_host  = (scan_pend_q && host_req) ? ~last_host_q : host_req;
          grant_scan  = ~grant_host;
          state_d     = S_ISSUE;
          is_host_d   = grant_host;
          last_host_d = grant_host;
          if (grant_host) begin
            dwe_d   = host_we;
            daddr_d = host_addr;
            di_d    = host_wdata;
          end else begin
            dwe_d   = 1'b0;
            daddr_d = slot_addr;
            di_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = 8'd1;
        if (drp_drdy) done_ok = 1'b1;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy)               done_ok  = 1'b1;
        else if (cnt_q == CNT_LAST) done_err = 1'b1;
        else                        cnt_d    = cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_scan) scan_pend_d = 1'b0;
    if (eoc_in)     scan_pend_d = 1'b1;

    // Result registers are loaded on entry to DONE so the pulses line up with it
    if (done_ok || done_err) begin
      state_d = S_DONE;
      if (is_host_q) begin
        host_ack_d = done_ok;
        host_err_d = done_err;
        if (done_ok && !dwe_q) host_rdata_d = drp_do;
      end else begin
        slot_d = slot_q + 2'd1;
        if (done_ok) begin
          data_d[slot_q] = drp_do[15:8];
          sample_stb_d   = 1'b1;
          sample_idx_d   = slot_q;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scan_pend_q  <= 1'b0;
      eoc_ovr_q    <= 1'b0;
      last_host_q  <= 1'b0;
      slot_q       <= '0;
      is_host_q    <= 1'b0;
      dwe_q        <= 1'b0;
      daddr_q      <= '0;
      di_q         <= '0;
      cnt_q        <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
      data_q       <= '0;
      sample_stb_q <= 1'b0;
      sample_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      scan_pend_q  <= scan_pend_d;
      eoc_ovr_q    <= eoc_ovr_d;
      last_host_q  <= last_host_d;
      slot_q       <= slot_d;
      is_host_q    <= is_host_d;
      dwe_q        <= dwe_d;
      daddr_q      <= daddr_d;
      di_q         <= di_d;
      cnt_q        <= cnt_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
      data_q       <= data_d;
      sample_stb_q <= sample_stb_d;
      sample_idx_q <= sample_idx_d;
    end
  end

  assign drp_den    = (state_q == S_ISSUE);
  assign drp_dwe    = drp_den & dwe_q;
  assign drp_daddr  = daddr_q;
  assign drp_di     = di_q;
  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;
  assign data0      = data_q[0];
  assign data1      = data_q[1];
  assign data2      = data_q[2];
  assign data3      = data_q[3];
  assign sample_stb = sample_stb_q;
  assign sample_idx = sample_idx_q;
  assign eoc_ovr    = eoc_ovr_q;

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Self-checking bench for xadc_drp_sched: directed vector table, hand-written
// arbitration/overflow/reset sequences and randomized transactions checked
// against a transaction-level model.
`timescale 1ns/1ps
module tb_xadc_drp_sched;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc_in = 1'b0;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack, host_err;
  logic [15:0] host_rdata;
  logic [7:0]  data0, data1, data2, data3;
  logic        sample_stb;
  logic [1:0]  sample_idx;
  logic        eoc_ovr;

  xadc_drp_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .sample_stb(sample_stb), .sample_idx(sample_idx), .eoc_ovr(eoc_ovr)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- DRP slave model ----------------
  int          rsp_lat  = 1;      // -1: never answer
  logic [15:0] rsp_data = '0;
  int          rsp_cnt  = 0;

  initial forever begin
    @(negedge clk);
    drp_drdy = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin drp_drdy = 1'b1; drp_do = rsp_data; end
    end
    if (drp_den) begin
      if (rsp_lat == 0)     begin drp_drdy = 1'b1; drp_do = rsp_data; end
      else if (rsp_lat > 0) rsp_cnt = rsp_lat;
    end
  end

  // ---------------- output monitor ----------------
  typedef struct { int cyc; logic dwe; logic [6:0] addr; logic [15:0] di; } den_t;
  den_t       den_log[$];
  int         cyc = 0, ack_n = 0, err_n = 0, stb_n = 0;
  int         ack_cyc = 0, err_cyc = 0, stb_cyc = 0;
  logic [1:0] stb_idx = '0;
  int         overlap = 0;
  logic       prev_den = 1'b0;

  initial forever begin
    den_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (drp_den) begin
      e.cyc = cyc; e.dwe = drp_dwe; e.addr = drp_daddr; e.di = drp_di;
      den_log.push_back(e);
      if (prev_den) overlap++;
    end
    if (!drp_den && drp_dwe) overlap++;
    prev_den = drp_den;
    if (host_ack)   begin ack_n++; ack_cyc = cyc; end
    if (host_err)   begin err_n++; err_cyc = cyc; end
    if (sample_stb) begin stb_n++; stb_cyc = cyc; stb_idx = sample_idx; end
  end

  task automatic clear_log();
    den_log.delete();
    ack_n = 0; err_n = 0; stb_n = 0;
  endtask

  function automatic logic [15:0] data_of(input int idx);
    case (idx)
      0:       return {8'h00, data0};
      1:       return {8'h00, data1};
      2:       return {8'h00, data2};
      default: return {8'h00, data3};
    endcase
  endfunction

  task automatic wait_ack(input int target);
    int n = 0;
    while (ack_n + err_n < target && n < TO + 20) begin @(negedge clk); n++; end
    check("wait_host_done", ack_n + err_n, target);
  endtask

  task automatic wait_stb(input int target);
    int n = 0;
    while (stb_n < target && n < TO + 20) begin @(negedge clk); n++; end
    check("wait_sample_stb", stb_n, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_den"}, drp_den, 0);
    check({tag, "_dwe"}, drp_dwe, 0);
    check({tag, "_daddr"}, drp_daddr, 0);
    check({tag, "_di"}, drp_di, 0);
    check({tag, "_ack_err"}, {host_ack, host_err}, 0);
    check({tag, "_rdata"}, host_rdata, 0);
    check({tag, "_data"}, {data0, data1, data2, data3}, 0);
    check({tag, "_stb_idx"}, {sample_stb, sample_idx}, 0);
    check({tag, "_ovr"}, eoc_ovr, 0);
  endtask

  task automatic reset_dut();
    host_req = 1'b0; eoc_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- single transaction ----------------
  typedef struct {
    logic        is_host;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rsp;
    logic [6:0]  exp_daddr;
    logic        exp_err;
    logic        exp_stb;
    logic [1:0]  exp_idx;
    logic [15:0] exp_word;   // host: host_rdata, scan: data of exp_idx
  } vec_t;

  task automatic do_op(input vec_t v);
    int   n = 0;
    int   lat_exp;
    logic done = 1'b0;
    den_t e;
    clear_log();
    rsp_lat = v.lat; rsp_data = v.rsp;
    if (v.is_host) begin
      host_we = v.we; host_addr = v.addr; host_wdata = v.wdata; host_req = 1'b1;
    end else begin
      eoc_in = 1'b1;
    end
    @(negedge clk);
    eoc_in = 1'b0;
    while (!done && n < TO + 20) begin
      if (v.is_host ? (ack_n + err_n > 0) : (stb_n > 0)) done = 1'b1;
      else begin @(negedge clk); n++; end
    end
    host_req = 1'b0;
    if (v.is_host) check("host_done", done, 1);
    repeat (3) @(negedge clk);

    lat_exp = (v.lat <= 0) ? 1 : v.lat + 1;
    check("den_count", den_log.size(), 1);
    if (den_log.size() >= 1) begin
      e = den_log[0];
      check("den_daddr", e.addr, v.exp_daddr);
      check("den_dwe", e.dwe, v.is_host ? v.we : 1'b0);
      if (v.is_host && v.we) check("den_di", e.di, v.wdata);
      if (v.is_host) begin
        check("host_ack", ack_n, v.exp_err ? 0 : 1);
        check("host_err", err_n, v.exp_err ? 1 : 0);
        if (v.exp_err) check("err_latency", err_cyc - e.cyc, TO);
        else           check("ack_latency", ack_cyc - e.cyc, lat_exp);
        check("host_rdata", host_rdata, v.exp_word);
      end else begin
        check("stb_count", stb_n, v.exp_stb ? 1 : 0);
        if (v.exp_stb) begin
          check("stb_idx", stb_idx, v.exp_idx);
          check("stb_latency", stb_cyc - e.cyc, lat_exp);
        end
        check("data_slot", data_of(v.exp_idx), v.exp_word);
      end
    end
  endtask

  // ---------------- reference model state ----------------
  logic [6:0]  ch_addr [4] = '{7'h1E, 7'h17, 7'h1F, 7'h16};
  logic [7:0]  m_data  [4];
  logic [15:0] m_rdata;
  int          m_slot;

  vec_t tbl [11];
  vec_t v;

  initial begin
    // is_host we addr wdata lat rsp | exp_daddr err stb idx word
    tbl[0]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  2, 16'hA511, 7'h1E, 1'b0, 1'b1, 2'd0, 16'h00A5};
    tbl[1]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  1, 16'h5A22, 7'h17, 1'b0, 1'b1, 2'd1, 16'h005A};
    tbl[2]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  3, 16'h3C33, 7'h1F, 1'b0, 1'b1, 2'd2, 16'h003C};
    tbl[3]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  0, 16'hC344, 7'h16, 1'b0, 1'b1, 2'd3, 16'h00C3};
    tbl[4]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  2, 16'h7E55, 7'h1E, 1'b0, 1'b1, 2'd0, 16'h007E};
    tbl[5]  = '{1'b1, 1'b0, 7'h00, 16'h0000,  3, 16'h1234, 7'h00, 1'b0, 1'b0, 2'd0, 16'h1234};
    tbl[6]  = '{1'b1, 1'b1, 7'h41, 16'h2000,  1, 16'hBEEF, 7'h41, 1'b0, 1'b0, 2'd0, 16'h1234};
    tbl[7]  = '{1'b1, 1'b0, 7'h10, 16'h0000, -1, 16'h9876, 7'h10, 1'b1, 1'b0, 2'd0, 16'h1234};
    tbl[8]  = '{1'b0, 1'b0, 7'h00, 16'h0000,  1, 16'h9900, 7'h17, 1'b0, 1'b1, 2'd1, 16'h0099};
    tbl[9]  = '{1'b0, 1'b0, 7'h00, 16'h0000, -1, 16'hFFFF, 7'h1F, 1'b0, 1'b0, 2'd2, 16'h003C};
    tbl[10] = '{1'b0, 1'b0, 7'h00, 16'h0000,  1, 16'h0101, 7'h16, 1'b0, 1'b1, 2'd3, 16'h0001};

    reset_dut();
    check_all_zero("reset");

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    // Host request and eoc together, scan served last: host first, then slot 0
    clear_log();
    rsp_lat = 1; rsp_data = 16'h4400;
    host_we = 1'b1; host_addr = 7'h41; host_wdata = 16'h2000; host_req = 1'b1; eoc_in = 1'b1;
    @(negedge clk);
    eoc_in = 1'b0;
    wait_ack(1);
    host_req = 1'b0;
    wait_stb(1);
    repeat (3) @(negedge clk);
    check("arb_den_count", den_log.size(), 2);
    if (den_log.size() == 2) begin
      check("arb_first", {den_log[0].dwe, den_log[0].addr, den_log[0].di}, {1'b1, 7'h41, 16'h2000});
      check("arb_second", {den_log[1].dwe, den_log[1].addr}, {1'b0, 7'h1E});
    end
    check("arb_data0", data0, 8'h44);
    check("arb_no_ovr", eoc_ovr, 0);

    // Tie with host served last: scan wins, then the held host request
    clear_log();
    rsp_lat = 10; rsp_data = 16'h1111;
    host_we = 1'b0; host_addr = 7'h05; host_req = 1'b1;
    repeat (4) @(negedge clk);
    eoc_in = 1'b1;
    @(negedge clk);
    eoc_in = 1'b0;
    wait_ack(1);
    check("tie_rdata1", host_rdata, 16'h1111);
    host_addr = 7'h06; rsp_lat = 2; rsp_data = 16'h6600;
    wait_ack(2);
    host_req = 1'b0;
    repeat (5) @(negedge clk);
    check("tie_den_count", den_log.size(), 3);
    if (den_log.size() == 3)
      check("tie_order", {den_log[0].addr, den_log[1].addr, den_log[2].addr}, {7'h05, 7'h17, 7'h06});
    check("tie_stb", {stb_n[3:0], stb_idx}, {4'd1, 2'd1});
    check("tie_data1", data1, 8'h66);
    check("tie_rdata2", host_rdata, 16'h6600);
    check("tie_no_ovr", eoc_ovr, 0);

    // Two eoc during a long host access: overflow flag, one scan afterwards
    clear_log();
    rsp_lat = 30; rsp_data = 16'h2222;
    host_we = 1'b0; host_addr = 7'h07; host_req = 1'b1;
    repeat (5) @(negedge clk);
    eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
    repeat (5) @(negedge clk);
    eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
    wait_ack(1);
    host_req = 1'b0;
    rsp_lat = 1;
    wait_stb(1);
    repeat (12) @(negedge clk);
    check("ovr_flag", eoc_ovr, 1);
    check("ovr_den_count", den_log.size(), 2);
    if (den_log.size() == 2) check("ovr_scan_addr", den_log[1].addr, 7'h1F);
    check("ovr_stb_count", stb_n, 1);
    check("ovr_data2", data2, 8'h22);

    // Reset during WAIT of a scan; the late drdy must be ignored
    clear_log();
    rsp_lat = 8; rsp_data = 16'hDD00;
    eoc_in = 1'b1; @(negedge clk); eoc_in = 1'b0;
    for (int n = 0; n < 10 && den_log.size() == 0; n++) @(negedge clk);
    check("rst_scan_started", den_log.size(), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (15) @(negedge clk);
    check("rst_no_den", den_log.size(), 0);
    check("rst_no_stb", stb_n, 0);
    check("rst_data", {data0, data1, data2, data3}, 0);
    v = '{1'b0, 1'b0, 7'h00, 16'h0000, 1, 16'h1700, 7'h1E, 1'b0, 1'b1, 2'd0, 16'h0017};
    do_op(v);

    // Randomized transactions against the transaction-level model
    reset_dut();
    m_slot = 0; m_rdata = '0;
    for (int k = 0; k < 4; k++) m_data[k] = '0;
    for (int i = 0; i < 40; i++) begin
      v.is_host = 1'($urandom_range(0, 1));
      v.we      = 1'($urandom_range(0, 1));
      v.addr    = 7'($urandom);
      v.wdata   = 16'($urandom);
      v.lat     = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      v.rsp     = 16'($urandom);
      v.exp_err = v.is_host && (v.lat < 0);
      if (v.is_host) begin
        v.exp_daddr = v.addr;
        if (v.lat >= 0 && !v.we) m_rdata = v.rsp;
        v.exp_word = m_rdata;
        v.exp_stb  = 1'b0;
        v.exp_idx  = 2'd0;
      end else begin
        v.exp_daddr = ch_addr[m_slot];
        v.exp_idx   = 2'(m_slot);
        v.exp_stb   = (v.lat >= 0);
        if (v.exp_stb) m_data[m_slot] = v.rsp[15:8];
        v.exp_word  = {8'h00, m_data[m_slot]};
        m_slot      = (m_slot + 1) % 4;
      end
      do_op(v);
      for (int k = 0; k < 4; k++) check("model_data", data_of(k), {8'h00, m_data[k]});
    end

    check("no_overlapping_den", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_drp_sched.md
Name: xadc_drp_sched

Overview:
- Sequences the XADC DRP port: round-robin scan of the four auxiliary channels, triggered by end-of-conversion.
- Shares the same DRP port with a host read/write request port, so configuration and status accesses do not collide with scan reads.
- Holds the latest upper byte of each channel for the LED PWM logic.
- Sits between the XADC wizard instance and the rest of the top level.

Parameters:
- CH0_ADDR, 7'h1E, DRP address of scan slot 0
- CH1_ADDR, 7'h17, DRP address of scan slot 1
- CH2_ADDR, 7'h1F, DRP address of scan slot 2
- CH3_ADDR, 7'h16, DRP address of scan slot 3
- TIMEOUT, 64, cycles after den with no drdy before the access is abandoned (2..255)

Ports:
- clk  in  1  system clock, also drives XADC dclk
- rst_n  in  1  asynchronous active-low reset
- eoc_in  in  1  XADC end-of-conversion pulse
- drp_den  out  1  DRP enable, single-cycle pulse
- drp_dwe  out  1  DRP write enable, valid with den
- drp_daddr  out  7  DRP address, valid with den
- drp_di  out  16  DRP write data, valid with den
- drp_do  in  16  DRP read data, valid with drdy
- drp_drdy  in  1  DRP ready
- host_req  in  1  host access request, held until host_ack or host_err
- host_we  in  1  1 = write, 0 = read; sampled at grant
- host_addr  in  7  host DRP address; sampled at grant
- host_wdata  in  16  host write data; sampled at grant
- host_ack  out  1  one-cycle pulse, access completed
- host_err  out  1  one-cycle pulse, access timed out
- host_rdata  out  16  read data, valid from host_ack until the next host access completes
- data0..data3  out  8 each  latest drp_do[15:8] per scan slot
- sample_stb  out  1  one-cycle pulse when a dataN register updates
- sample_idx  out  2  slot index updated with sample_stb
- eoc_ovr  out  1  sticky flag, eoc arrived while a scan was already pending; cleared only by reset

Behaviour:
- Reset (asynchronous, rst_n low) sets all outputs, dataN, slot index, scan_pend and last_grant to 0; state goes to IDLE.
- Reset mid-access leaves drp_den low immediately. A drdy arriving after reset release while in IDLE is ignored.
- scan_pend is set on any cycle with eoc_in=1. It clears when a scan access is granted.
  - eoc_in while scan_pend=1 sets eoc_ovr.
  - eoc_in in the same cycle as a scan grant re-sets scan_pend.
- FSM states:
  - IDLE → ISSUE when scan_pend or host_req is set.
    - Only one requester: grant it.
    - Both requesters: grant the one not granted last (last_grant toggles), so neither starves.
    - The grant latches the request type, address, we and wdata. A scan uses CHn_ADDR for the current slot with we=0 and di=0.
  - ISSUE (1 cycle): drp_den=1 with the latched dwe, daddr and di. Load the timeout counter. Go to WAIT.
  - WAIT: count cycles.
    - drp_drdy=1 → DONE.
    - Counter reaches TIMEOUT → DONE with the error flag set.
    - A drdy in the ISSUE cycle itself is also accepted.
  - DONE (1 cycle), then back to IDLE:
    - Host access: host_ack=1, or host_err=1 on timeout. host_rdata captures drp_do on a read; it is unchanged on a write or timeout.
    - Scan access: on success, dataN ← drp_do[15:8], sample_stb=1, sample_idx=slot. On timeout, dataN is unchanged and there is no strobe.
    - In both cases the slot index increments 0→1→2→3→0, wrapping.
- DRP is never issued while an access is outstanding: at most one den per ISSUE, and no den in WAIT, DONE or IDLE.
- Minimum access time is 4 cycles from grant to return to IDLE (IDLE→ISSUE→WAIT→DONE, drdy arriving the cycle after den).
- drp_daddr, drp_dwe and drp_di hold their latched values outside ISSUE. drp_dwe is driven 0 outside ISSUE.
- host_req dropped by the host before ack is a protocol violation. The access still completes and the ack is still pulsed.

Test Plan:
- Reset, then 4 eoc pulses spaced 20 cycles; the DRP model returns 16'hA5xx, 16'h5Axx, 16'h3Cxx, 16'hC3xx → daddr sequence 1E, 17, 1F, 16; data0..3 = A5, 5A, 3C, C3; sample_idx 0..3; the 5th eoc reads 1E again.
- Host read of addr 7'h00 with no eoc, model returns 16'h1234 after 3 cycles → one den with dwe=0, daddr=00; host_ack pulse; host_rdata=16'h1234.
- Host write addr 7'h41 data 16'h2000 asserted in the same cycle as eoc, with last_grant=scan → host granted first (den, dwe=1, di=2000), then the scan read of the current slot, no overlapping den.
- Model never asserts drdy on a host read → host_err pulses exactly TIMEOUT cycles after den, host_rdata unchanged. A following scan proceeds normally.
- Two eoc pulses during a long host access → eoc_ovr=1 and only one scan executes afterwards.
- Assert rst_n low during WAIT of a scan, then release → all dataN=0, slot index 0, no sample_stb. A late drdy is ignored. The next eoc reads daddr 1E.
